// File: rtl/somador_arbiter_pkg.sv
// somador_arb_pkg: shared state encoding, default sizes and clog2 helper for the arbiter
package somador_arb_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4
  } state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/somador_arbiter_if.sv
// somador_arbiter_if: requester bus and adder control signals shared by the arbiter and its clients
interface somador_arbiter_if import somador_arb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = DEF_NREQ
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [NREQ*WIDTH-1:0] opA_bus;
  logic [NREQ*WIDTH-1:0] opB_bus;
  logic [WIDTH-1:0] res_out;
  logic [WIDTH-1:0] adder_A;
  logic [WIDTH-1:0] adder_B;
  logic [WIDTH-1:0] adder_res;
  logic [clog2(NREQ)-1:0] gnt_id;
  logic busy;
  logic err;
  logic adder_S;
  logic adder_RESET;
  logic adder_done;
  modport slave (
    input req, opA_bus, opB_bus, adder_done, adder_res,
    output ack, res_out, gnt_id, busy, err, adder_S, adder_RESET, adder_A, adder_B
  );
  modport master (
    output req, opA_bus, opB_bus, adder_done, adder_res,
    input ack, res_out, gnt_id, busy, err, adder_S, adder_RESET, adder_A, adder_B
  );
endinterface

// File: rtl/somador_arbiter_rr_picker.sv
// rr_picker: first set request searching cyclically from last+1
module rr_picker import somador_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  localparam int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            any_req,
  output logic [IW-1:0]   next_id
);
  localparam logic [IW:0] NR = (IW + 1)'(NREQ);
  logic [IW:0] sh, s;
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  assign any_req = |req;
  // rotate so bit 0 is requester last+1, then the lowest set bit wins
  always_comb begin
    sh = {1'b0, last} + 1'b1;
    rot = NREQ'({req, req} >> sh);
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) off = rot[j] ? IW'(j) : off;
    s = {1'b0, last} + 1'b1 + {1'b0, off};
    next_id = (s >= NR) ? IW'(s - NR) : IW'(s);
  end
endmodule

// File: rtl/somador_arbiter.sv
// somador_arbiter: round-robin sharing of one adder among NREQ requesters; ARB_TIMEOUT_EN adds a WAIT timeout abort
module somador_arbiter import somador_arb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = DEF_NREQ,
  parameter int TIMEOUT_CYC = 32
) (
  input logic clk,
  input logic RESET,
  somador_arbiter_if.slave bus
);
  localparam int IW = clog2(NREQ);
  state_t state;
  logic [IW-1:0] last, next_id;
  logic any_req, rst_q;
  rr_picker #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .last(last),
    .any_req(any_req),
    .next_id(next_id)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic to_q;
  assign bus.err = (state == CAPTURE) & to_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.ack = (state == CAPTURE) ? NREQ'(1) << bus.gnt_id : '0;
  assign bus.busy = state != IDLE;
  assign bus.adder_S = state == GRANT;
  // the adder's done state is terminal, so it is re-armed after reset as well as after each operation
  assign bus.adder_RESET = rst_q | (state == RELEASE);
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
      bus.gnt_id <= '0;
      bus.adder_A <= '0;
      bus.adder_B <= '0;
      bus.res_out <= '0;
      last <= IW'(NREQ - 1);
      rst_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      tcnt <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      rst_q <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          state <= GRANT;
          bus.gnt_id <= next_id;
          bus.adder_A <= bus.opA_bus[int'(next_id)*WIDTH +: WIDTH];
          bus.adder_B <= bus.opB_bus[int'(next_id)*WIDTH +: WIDTH];
        end
        GRANT: begin
          state <= WAIT;
`ifdef ARB_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        WAIT: if (bus.adder_done) begin
          bus.res_out <= bus.adder_res;
          state <= CAPTURE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT_CYC)) begin
          bus.res_out <= '0;
          to_q <= 1'b1;
          state <= CAPTURE;
        end else tcnt <= tcnt + 1'b1;
`endif
        CAPTURE: begin
          last <= bus.gnt_id;
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
`ifdef ARB_TIMEOUT_EN
          to_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_somador_arbiter.sv
// tb_somador_arbiter: directed checks of arbitration order, latency, operand latching and reset
module tb_somador_arbiter;
  import somador_arb_pkg::*;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic RESET;
  int vecs = 0;
  int errs = 0;
  int lat = 7;
  int cnt = 0;
  always #5 clk = ~clk;
  somador_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
  somador_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT_CYC(32)) dut (.clk(clk), .RESET(RESET), .bus(bus));
  // adder model: done rises lat cycles after the S cycle (lat=0 never finishes), result is A+B
  always @(posedge clk) begin
    if (bus.adder_RESET) begin
      bus.adder_done <= 1'b0;
      cnt <= 0;
    end else if (bus.adder_S) cnt <= lat - 1;
    else if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt <= 0;
      bus.adder_done <= 1'b1;
      bus.adder_res <= bus.adder_A + bus.adder_B;
    end
  end
  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.opA_bus[i*W +: W] = a;
    bus.opB_bus[i*W +: W] = b;
  endtask
  task automatic wait_ack(output logic [N-1:0] a, output logic [W-1:0] r, output logic [1:0] g);
    a = '0;
    r = '0;
    g = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        a = bus.ack;
        r = bus.res_out;
        g = bus.gnt_id;
        break;
      end
    end
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    bus.req = '0;
    bus.opA_bus = '0;
    bus.opB_bus = '0;
    repeat (3) @(negedge clk);
    vecs++; if (bus.ack !== 4'b0) begin errs++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    vecs++; if (bus.res_out !== 8'h00) begin errs++; $display("FAIL reset_res got %h want 00", bus.res_out); end
    vecs++; if (bus.gnt_id !== 2'd0) begin errs++; $display("FAIL reset_gnt got %0d want 0", bus.gnt_id); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", bus.err); end
    vecs++; if (bus.adder_S !== 1'b0) begin errs++; $display("FAIL reset_S got %b want 0", bus.adder_S); end
    vecs++; if ({bus.adder_A, bus.adder_B} !== 16'h0) begin errs++; $display("FAIL reset_AB got %h want 0000", {bus.adder_A, bus.adder_B}); end
    vecs++; if (bus.adder_RESET !== 1'b1) begin errs++; $display("FAIL reset_rearm got %b want 1", bus.adder_RESET); end
    RESET = 1'b0;
    @(negedge clk);
    vecs++; if (bus.adder_RESET !== 1'b0) begin errs++; $display("FAIL reset_rearm_drop got %b want 0", bus.adder_RESET); end
  endtask
  task automatic test_back_to_back;
    logic [N-1:0] a;
    logic [W-1:0] r;
    logic [1:0] g;
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] exp_res [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    set_ops(0, 8'h01, 8'h10);
    set_ops(1, 8'h02, 8'h20);
    set_ops(2, 8'h03, 8'h30);
    set_ops(3, 8'h04, 8'h40);
    lat = 3;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(a, r, g);
      vecs++; if (a !== 4'b0001 << exp_id[i]) begin errs++; $display("FAIL rr_ack[%0d] got %b want %b", i, a, 4'b0001 << exp_id[i]); end
      vecs++; if (g !== exp_id[i]) begin errs++; $display("FAIL rr_gnt[%0d] got %0d want %0d", i, g, exp_id[i]); end
      vecs++; if (r !== exp_res[exp_id[i]]) begin errs++; $display("FAIL rr_res[%0d] got %h want %h", i, r, exp_res[exp_id[i]]); end
      if (i == 4) bus.req = 4'b0101;
      @(negedge clk);
      vecs++; if (bus.ack !== 4'b0) begin errs++; $display("FAIL rr_ack_pulse[%0d] got %b want 0000", i, bus.ack); end
      vecs++; if (bus.adder_RESET !== 1'b1 || bus.busy !== 1'b1) begin errs++; $display("FAIL rr_release[%0d] got rearm=%b busy=%b want 1 1", i, bus.adder_RESET, bus.busy); end
      @(negedge clk);
      vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rr_idle[%0d] got busy=%b want 0", i, bus.busy); end
    end
  endtask
  task automatic test_rr_skip;
    logic [N-1:0] a;
    logic [W-1:0] r;
    logic [1:0] g;
    wait_ack(a, r, g);
    vecs++; if (a !== 4'b0100 || g !== 2'd2 || r !== 8'h33) begin errs++; $display("FAIL skip_first got ack=%b gnt=%0d res=%h want 0100 2 33", a, g, r); end
    wait_ack(a, r, g);
    vecs++; if (a !== 4'b0001 || g !== 2'd0 || r !== 8'h11) begin errs++; $display("FAIL skip_second got ack=%b gnt=%0d res=%h want 0001 0 11", a, g, r); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_single;
    set_ops(0, 8'h05, 8'hFD);
    lat = 7;
    bus.req = 4'b0001;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      vecs++; if (bus.adder_S !== (n == 1)) begin errs++; $display("FAIL single_S c%0d got %b want %b", n, bus.adder_S, n == 1); end
      vecs++; if (bus.ack !== ((n == 9) ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL single_ack c%0d got %b want %b", n, bus.ack, (n == 9) ? 4'b0001 : 4'b0000); end
      vecs++; if (bus.adder_RESET !== (n == 10)) begin errs++; $display("FAIL single_rearm c%0d got %b want %b", n, bus.adder_RESET, n == 10); end
      vecs++; if (bus.busy !== (n <= 10)) begin errs++; $display("FAIL single_busy c%0d got %b want %b", n, bus.busy, n <= 10); end
      if (n == 1) begin
        vecs++; if (bus.adder_A !== 8'h05 || bus.adder_B !== 8'hFD || bus.gnt_id !== 2'd0) begin errs++; $display("FAIL single_grant got A=%h B=%h gnt=%0d want 05 FD 0", bus.adder_A, bus.adder_B, bus.gnt_id); end
      end
      if (n == 9) begin
        vecs++; if (bus.res_out !== 8'h02) begin errs++; $display("FAIL single_res got %h want 02", bus.res_out); end
        bus.req = '0;
      end
    end
  endtask
  task automatic test_operand_hold;
    logic [N-1:0] a;
    logic [W-1:0] r;
    logic [1:0] g;
    set_ops(1, 8'h07, 8'h03);
    lat = 5;
    bus.req = 4'b0010;
    @(negedge clk);
    vecs++; if (bus.gnt_id !== 2'd1 || bus.adder_A !== 8'h07) begin errs++; $display("FAIL hold_grant got gnt=%0d A=%h want 1 07", bus.gnt_id, bus.adder_A); end
    set_ops(1, 8'h50, 8'h03);
    bus.req = '0;
    repeat (2) @(negedge clk);
    vecs++; if (bus.adder_A !== 8'h07) begin errs++; $display("FAIL hold_A got %h want 07", bus.adder_A); end
    wait_ack(a, r, g);
    vecs++; if (a !== 4'b0010 || r !== 8'h0A) begin errs++; $display("FAIL hold_ack got ack=%b res=%h want 0010 0A", a, r); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_midop;
    logic [N-1:0] a;
    logic [W-1:0] r;
    logic [1:0] g;
    set_ops(2, 8'h03, 8'h30);
    lat = 20;
    bus.req = 4'b0100;
    repeat (5) @(negedge clk);
    vecs++; if (bus.busy !== 1'b1 || bus.gnt_id !== 2'd2) begin errs++; $display("FAIL midop_wait got busy=%b gnt=%0d want 1 2", bus.busy, bus.gnt_id); end
    RESET = 1'b1;
    bus.req = '0;
    @(negedge clk);
    RESET = 1'b0;
    vecs++; if (bus.ack !== 4'b0 || bus.res_out !== 8'h00) begin errs++; $display("FAIL midop_clear got ack=%b res=%h want 0000 00", bus.ack, bus.res_out); end
    vecs++; if (bus.adder_RESET !== 1'b1 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0) begin errs++; $display("FAIL midop_state got rearm=%b busy=%b gnt=%0d want 1 0 0", bus.adder_RESET, bus.busy, bus.gnt_id); end
    @(negedge clk);
    set_ops(0, 8'h01, 8'h10);
    lat = 3;
    bus.req = 4'b0111;
    wait_ack(a, r, g);
    vecs++; if (a !== 4'b0001 || r !== 8'h11) begin errs++; $display("FAIL midop_after got ack=%b res=%h want 0001 11", a, r); end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask
`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    lat = 0;
    bus.req = 4'b0001;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      vecs++; if (bus.err !== (n == 35)) begin errs++; $display("FAIL to_err c%0d got %b want %b", n, bus.err, n == 35); end
      vecs++; if (bus.ack !== ((n == 35) ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL to_ack c%0d got %b", n, bus.ack); end
      if (n == 35) begin
        vecs++; if (bus.res_out !== 8'h00) begin errs++; $display("FAIL to_res got %h want 00", bus.res_out); end
        bus.req = '0;
      end
      if (n == 36) begin
        vecs++; if (bus.adder_RESET !== 1'b1) begin errs++; $display("FAIL to_rearm got %b want 1", bus.adder_RESET); end
      end
      if (n == 37) begin
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL to_idle got busy=%b want 0", bus.busy); end
      end
    end
  endtask
`endif
  initial begin
    test_reset;
    test_back_to_back;
    test_rr_skip;
    test_single;
    test_operand_hold;
    test_reset_midop;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
